// File: rtl/itcm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : itcm_arbiter
// Description : Single-port ITCM SRAM arbiter between the fetch path and the
//               data-side port. One access per cycle, data side wins unless
//               fetch has been starved, 1-cycle read data routed back to the
//               owning requester with flush suppression for fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module itcm_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ITCM_AW      = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    // fetch port
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic                  if_gnt,
    output logic                  if_rdata_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    // data-side port
    input  logic                  ds_req,
    input  logic                  ds_we,
    input  logic [ADDR_WIDTH-1:0] ds_addr,
    input  logic [3:0]            ds_be,
    input  logic [DATA_WIDTH-1:0] ds_wdata,
    output logic                  ds_gnt,
    output logic                  ds_rdata_valid,
    output logic [DATA_WIDTH-1:0] ds_rdata,
    // SRAM macro
    output logic                  itcm_cs,
    output logic                  itcm_we,
    output logic [3:0]            itcm_be,
    output logic [ITCM_AW-1:0]    itcm_addr,
    output logic [DATA_WIDTH-1:0] itcm_wdata,
    input  logic [DATA_WIDTH-1:0] itcm_rdata
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       rsp_if;
    logic       rsp_ds;
    logic       flush_kill;
    logic       fetch_forced;
    logic       ds_write;

    // Address bits outside the SRAM word index carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[ADDR_WIDTH-1:ITCM_AW+2], if_addr[1:0],
                                ds_addr[ADDR_WIDTH-1:ITCM_AW+2], ds_addr[1:0]};

    // Grants are combinational; reset blanks them immediately so the SRAM
    // sees no select while reset is asserted.
    assign fetch_forced = if_req && (starve_cnt == STARVE_MAX);
    assign ds_gnt       = ~cpu_rst & ds_req & ~fetch_forced;
    assign if_gnt       = ~cpu_rst & if_req & ~ds_gnt;
    assign ds_write     = ds_gnt & ds_we;

    // SRAM drive follows the winner; everything is zero when idle.
    always_comb begin
        itcm_cs    = if_gnt | ds_gnt;
        itcm_we    = ds_write;
        itcm_be    = 4'h0;
        itcm_addr  = '0;
        itcm_wdata = '0;
        if (ds_gnt) begin
            itcm_addr = ds_addr[ITCM_AW+1:2];
            itcm_be   = ds_we ? ds_be : 4'hF;
            if (ds_we) begin
                itcm_wdata = ds_wdata;
            end
        end else if (if_gnt) begin
            itcm_addr = if_addr[ITCM_AW+1:2];
            itcm_be   = 4'hF;
        end
    end

    // Count cycles fetch loses to the data side; any fetch win or a fetch
    // idle cycle clears the count.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= 4'd0;
        end else if (if_req && ds_req && ds_gnt) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Track which requester owns next cycle's SRAM read data.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            rsp_if     <= 1'b0;
            rsp_ds     <= 1'b0;
            flush_kill <= 1'b0;
        end else begin
            rsp_if     <= if_gnt;
            rsp_ds     <= ds_gnt & ~ds_we;
            flush_kill <= if_flush & if_gnt;
        end
    end

    // A redirect in either the grant or the response cycle drops the fetch data.
    assign if_rdata_valid = rsp_if & ~if_flush & ~flush_kill;
    assign ds_rdata_valid = rsp_ds;
    assign if_rdata       = if_rdata_valid ? itcm_rdata : '0;
    assign ds_rdata       = ds_rdata_valid ? itcm_rdata : '0;

endmodule
`default_nettype wire

// File: doc/itcm_arbiter.md
# itcm_arbiter

Shares the single-port instruction TCM SRAM between the core fetch path and a data-side port used for program loading and load/store accesses to ITCM. Arbitrates one access per cycle, drives the SRAM, and routes 1-cycle-latency read data back to the owning requester. Sits between fetch/imem control (`next_pc` side) and the ITCM macro, alongside the AHB path.

## Interface
- `ADDR_WIDTH`, 32, byte address width of both request ports
- `DATA_WIDTH`, 32, SRAM word / data width
- `ITCM_AW`, 14, SRAM word-address width (ITCM size = 4·2^ITCM_AW bytes)
- `STARVE_LIMIT`, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)

- `cpu_clk`  in  1  cpu clock; all state on rising edge
- `cpu_rst`  in  1  reset, asynchronous, active-high
- `if_req`  in  1  fetch read request
- `if_addr`  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
- `if_flush`  in  1  fetch redirect (jump/branch/trap/mret); kills in-flight fetch response
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rdata_valid`  out  1  fetch read data valid
- `if_rdata`  out  DATA_WIDTH  fetch read data
- `ds_req`  in  1  data-side request
- `ds_we`  in  1  1 = write, 0 = read
- `ds_addr`  in  ADDR_WIDTH  data-side byte address; bits [1:0] ignored
- `ds_be`  in  4  byte enables for writes
- `ds_wdata`  in  DATA_WIDTH  write data
- `ds_gnt`  out  1  data request accepted this cycle
- `ds_rdata_valid`  out  1  data read data valid (reads only)
- `ds_rdata`  out  DATA_WIDTH  data read data
- `itcm_cs`, `itcm_we`  out  1  SRAM select / write enable
- `itcm_be`  out  4  SRAM byte enables
- `itcm_addr`  out  ITCM_AW  SRAM word address = `addr[ITCM_AW+1:2]` of the winner
- `itcm_wdata`  out  DATA_WIDTH  SRAM write data
- `itcm_rdata`  in  DATA_WIDTH  SRAM read data, valid one cycle after a read select

## Operation
- Grant is combinational in the request cycle; a transfer occurs when `req & gnt`. At most one of `if_gnt`/`ds_gnt` high per cycle.
- Policy: data side wins by default. Starvation counter `starve_cnt` (4 bits) increments each cycle `if_req & ds_req & ds_gnt`; resets to 0 on any `if_gnt` or when `if_req` low. When `starve_cnt == STARVE_LIMIT`, fetch wins regardless of `ds_req`.
- Single requester always granted immediately.
- SRAM drive: `itcm_cs = if_gnt | ds_gnt`; `itcm_we = ds_gnt & ds_we`; `itcm_be = ds_gnt&ds_we ? ds_be : 4'hF`; wdata from `ds_wdata`. Outputs follow winner's address; zero when idle.
- Response tracking: registers `rsp_if` (set on fetch grant) and `rsp_ds` (set on data read grant), both cleared otherwise. Writes generate no response.
- `if_rdata_valid = rsp_if & ~if_flush & ~flush_kill`, where `flush_kill` registers `if_flush & if_gnt` (flush in the grant cycle also kills). `ds_rdata_valid = rsp_ds`.
- `if_rdata`/`ds_rdata` pass `itcm_rdata` through when respective valid, else 0.
- Data-side write followed next cycle by fetch read of same word returns new data (SRAM write-then-read ordering).

## Timing
- Reset (async assert): all outputs 0, `starve_cnt`=0, `rsp_if`=`rsp_ds`=`flush_kill`=0. Deassert synchronously honoured on next edge.
- Read latency: grant at cycle N -> rdata_valid at N+1; fully pipelined, back-to-back grants alternate owners with no bubble.
- Reset asserted with a read in flight: response dropped, no valid after release.
- `if_flush` in N (grant) or N+1 (response) suppresses that fetch response only; data responses unaffected; a new fetch granted in the flush cycle itself is also killed (fetch re-requests after redirect).
- Requests held high after grant are new requests each cycle (no implicit hold).

## Test plan
- Reset: assert `cpu_rst` mid-traffic -> all outputs 0 same cycle; no valids after release until new grant.
- Fetch only: `if_req`=1, addr 0x0,0x4,0x8 on consecutive cycles with SRAM preloaded 0xA,0xB,0xC -> `if_gnt`=1 each cycle, `if_rdata` 0xA,0xB,0xC one cycle later, `itcm_addr` 0,1,2.
- Contention/starvation, `STARVE_LIMIT`=4: both requesting continuously -> ds granted 4 cycles, fetch 5th, pattern repeats; counter resets on fetch grant.
- Write-then-read: ds write 0xDEADBEEF, be=4'b0011, to 0x10 over old 0x11223344, then fetch 0x10 -> `if_rdata`=0x1122BEEF.
- Flush: fetch granted at N with `if_flush` at N+1 -> `if_rdata_valid`=0 at N+1; ds read granted at N+1 returns valid at N+2.
- Mixed read order: ds read 0x20 then fetch 0x24 back-to-back -> `ds_rdata_valid` at N+1 only, `if_rdata_valid` at N+2 only, correct data each.
